// File: rtl/mem_req_arbiter_if.sv
// Bundle of two-port requester handshakes, memory-side port and status for mem_req_arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface mem_req_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              rq0_valid;
  logic              rq0_we;
  logic [ADDR_W-1:0] rq0_addr;
  logic [DATA_W-1:0] rq0_wdata;
  logic              rq0_ready;
  logic              rs0_valid;
  logic [DATA_W-1:0] rs0_rdata;

  logic              rq1_valid;
  logic              rq1_we;
  logic [ADDR_W-1:0] rq1_addr;
  logic [DATA_W-1:0] rq1_wdata;
  logic              rq1_ready;
  logic              rs1_valid;
  logic [DATA_W-1:0] rs1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic              mem_load_req;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_load_completed;
  logic              mem_store_completed;

  logic              busy;

  modport slave (
    input  rq0_valid, rq0_we, rq0_addr, rq0_wdata,
    input  rq1_valid, rq1_we, rq1_addr, rq1_wdata,
    input  mem_rdata, mem_load_completed, mem_store_completed,
    output rq0_ready, rs0_valid, rs0_rdata,
    output rq1_ready, rs1_valid, rs1_rdata,
    output mem_addr, mem_wdata, mem_wren, mem_load_req, busy
  );

  modport master (
    output rq0_valid, rq0_we, rq0_addr, rq0_wdata,
    output rq1_valid, rq1_we, rq1_addr, rq1_wdata,
    output mem_rdata, mem_load_completed, mem_store_completed,
    input  rq0_ready, rs0_valid, rs0_rdata,
    input  rq1_ready, rs1_valid, rs1_rdata,
    input  mem_addr, mem_wdata, mem_wren, mem_load_req, busy
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Two-port block load/store arbiter in front of a single memory, one transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to port 0.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for a request; grants a winner and latches its command
// LOAD      | mem_load_req held until mem_load_completed, rdata captured
// STORE     | mem_wren held until mem_store_completed
// STORE_REL | waits for mem_store_completed to drop before finishing
// RESP      | issues the one-cycle rs_valid pulse to the granted port
module mem_req_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  mem_req_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    STORE     = 3'd2,
    STORE_REL = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              id_q;
  logic              rdy0_q, rdy1_q;
  logic              rsv0_q, rsv1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              wren_q, ldreq_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              ptr_q;
`endif

  logic win_d;
  logic we_d;

  always_comb begin
    win_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // ptr_q names the port favoured on a tie
    win_d = (bus.rq0_valid && bus.rq1_valid) ? ptr_q : !bus.rq0_valid;
`else
    win_d = !bus.rq0_valid;
`endif
    we_d = win_d ? bus.rq1_we : bus.rq0_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      id_q     <= 1'b0;
      rdy0_q   <= 1'b0;
      rdy1_q   <= 1'b0;
      rsv0_q   <= 1'b0;
      rsv1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      wren_q   <= 1'b0;
      ldreq_q  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      rdy0_q <= 1'b0;
      rdy1_q <= 1'b0;
      rsv0_q <= 1'b0;
      rsv1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.rq0_valid || bus.rq1_valid) begin
            id_q    <= win_d;
            addr_q  <= win_d ? bus.rq1_addr : bus.rq0_addr;
            wdata_q <= win_d ? bus.rq1_wdata : bus.rq0_wdata;
            rdy0_q  <= !win_d;
            rdy1_q  <= win_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q   <= !win_d;
`endif
            if (we_d) begin
              wren_q  <= 1'b1;
              state_q <= STORE;
            end else begin
              ldreq_q <= 1'b1;
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (bus.mem_load_completed) begin
            ldreq_q <= 1'b0;
            if (id_q) rdata1_q <= bus.mem_rdata;
            else      rdata0_q <= bus.mem_rdata;
            state_q <= RESP;
          end
        end
        STORE: begin
          if (bus.mem_store_completed) begin
            wren_q  <= 1'b0;
            state_q <= STORE_REL;
          end
        end
        STORE_REL: begin
          if (!bus.mem_store_completed) state_q <= RESP;
        end
        RESP: begin
          rsv0_q  <= !id_q;
          rsv1_q  <= id_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rq0_ready    = rdy0_q;
  assign bus.rq1_ready    = rdy1_q;
  assign bus.rs0_valid    = rsv0_q;
  assign bus.rs1_valid    = rsv1_q;
  assign bus.rs0_rdata    = rdata0_q;
  assign bus.rs1_rdata    = rdata1_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_wren     = wren_q;
  assign bus.mem_load_req = ldreq_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter with a one-cycle-response memory model.
// Expected grant order follows MEM_ARB_ROUND_ROBIN_EN when defined.
module tb_mem_req_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m ();
  mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(m));

  // memory model: completion pulses one cycle after request, unwritten words read back their address
  logic          ld_c, st_c, spur;
  logic [DW-1:0] mrdata;
  logic [DW-1:0] mem [0:255];
  logic          wr_vld [0:255];

  assign m.mem_load_completed  = ld_c;
  assign m.mem_store_completed = st_c | spur;
  assign m.mem_rdata           = mrdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_c   <= 1'b0;
      st_c   <= 1'b0;
      mrdata <= '0;
    end else begin
      ld_c <= m.mem_load_req && !ld_c;
      if (m.mem_load_req && !ld_c)
        mrdata <= wr_vld[m.mem_addr[7:0]] ? mem[m.mem_addr[7:0]] : {16'h0, m.mem_addr};
      st_c <= m.mem_wren && !st_c;
      if (m.mem_wren && !st_c) begin
        mem[m.mem_addr[7:0]]    <= m.mem_wdata;
        wr_vld[m.mem_addr[7:0]] <= 1'b1;
      end
    end
  end

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p != 0) ? m.rq1_ready : m.rq0_ready;
  endfunction

  function automatic logic rsv(input int p);
    return (p != 0) ? m.rs1_valid : m.rs0_valid;
  endfunction

  function automatic logic [DW-1:0] rsd(input int p);
    return (p != 0) ? m.rs1_rdata : m.rs0_rdata;
  endfunction

  task automatic drive(input int p, input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    if (p != 0) begin
      m.rq1_valid = v; m.rq1_we = we; m.rq1_addr = a; m.rq1_wdata = wd;
    end else begin
      m.rq0_valid = v; m.rq0_we = we; m.rq0_addr = a; m.rq0_wdata = wd;
    end
  endtask

  // lat counts cycles from the visible ready pulse to the visible rs_valid pulse
  task automatic xact(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input bit spur_st, input string tag, output int lat, output logic [DW-1:0] rd);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    @(negedge clk);
    drive(p, 1'b1, we, a, wd);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rdy(p)) begin seen = 1'b1; break; end
    end
    chk({tag, "_ready"}, 32'(seen), 32'd1);
    chk({tag, "_loser_ready"}, 32'(rdy(1 - p)), 32'd0);
    if (spur_st) spur = 1'b1;
    @(negedge clk);
    drive(p, 1'b0, 1'b0, '0, '0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) spur = 1'b0;
      if (m.mem_wren || m.mem_load_req) begin
        chk({tag, "_mem_addr"}, 32'(m.mem_addr), 32'(a));
        if (m.mem_wren) chk({tag, "_mem_wdata"}, m.mem_wdata, wd);
      end
      if (rsv(p)) begin seen = 1'b1; break; end
    end
    chk({tag, "_rs_valid"}, 32'(seen), 32'd1);
    rd = rsd(p);
  endtask

  initial begin
    int            lat;
    logic [DW-1:0] rd;
    bit            seen, bad;
    int            g;
    int            exp_g [4];
    logic          prev0, prev1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    spur = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 256; i++) wr_vld[i] = 1'b0;
    prev0 = 1'b0;
    prev1 = 1'b0;

    fork
      forever begin
        @(negedge clk);
        chk("wren_and_load_req", 32'(m.mem_wren & m.mem_load_req), 32'd0);
        chk("rs0_valid_double", 32'(prev0 & m.rs0_valid), 32'd0);
        chk("rs1_valid_double", 32'(prev1 & m.rs1_valid), 32'd0);
        prev0 = m.rs0_valid;
        prev1 = m.rs1_valid;
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(m.busy), 32'd0);
    chk("rst_ctrl", 32'({m.mem_wren, m.mem_load_req, m.rq0_ready, m.rq1_ready, m.rs0_valid, m.rs1_valid}), 32'd0);
    chk("rst_mem_addr", 32'(m.mem_addr), 32'd0);
    chk("rst_mem_wdata", m.mem_wdata, 32'd0);
    chk("rst_rs0_rdata", m.rs0_rdata, 32'd0);
    chk("rst_rs1_rdata", m.rs1_rdata, 32'd0);
    rst_n = 1'b1;

    xact(0, 1'b0, 16'h0004, '0, 1'b0, "ld0", lat, rd);
    chk("ld0_latency", 32'(lat), 32'd3);
    chk("ld0_rdata", rd, 32'h0000_0004);

    xact(1, 1'b0, 16'h0040, '0, 1'b0, "ld1", lat, rd);
    chk("ld1_latency", 32'(lat), 32'd3);
    chk("ld1_rdata", rd, 32'h0000_0040);

    xact(1, 1'b1, 16'h0008, 32'hDEAD_BEEF, 1'b0, "st1", lat, rd);
    chk("st1_latency", 32'(lat), 32'd4);
    chk("st1_rdata_held", rd, 32'h0000_0040);
    chk("st1_rs0_untouched", m.rs0_rdata, 32'h0000_0004);
    chk("st1_mem_0008", mem[8], 32'hDEAD_BEEF);

    xact(1, 1'b0, 16'h0008, '0, 1'b0, "ld1_back", lat, rd);
    chk("ld1_back_rdata", rd, 32'hDEAD_BEEF);

    // both ports hold valid across four grants
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0010, '0);
    drive(1, 1'b1, 1'b0, 16'h0020, '0);
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (m.rq0_ready || m.rq1_ready) begin seen = 1'b1; break; end
      end
      chk($sformatf("arb%0d_ready", k), 32'(seen), 32'd1);
      chk($sformatf("arb%0d_one_ready", k), 32'(m.rq0_ready & m.rq1_ready), 32'd0);
      g = m.rq1_ready ? 1 : 0;
      chk($sformatf("arb%0d_grant", k), 32'(g), 32'(exp_g[k]));
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (rsv(g)) begin seen = 1'b1; break; end
      end
      chk($sformatf("arb%0d_rs_valid", k), 32'(seen), 32'd1);
      chk($sformatf("arb%0d_rdata", k), rsd(g), (g != 0) ? 32'h0000_0020 : 32'h0000_0010);
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (8) @(negedge clk);
    chk("arb_idle", 32'(m.busy), 32'd0);

    // reset pulse in the middle of a load
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0010, '0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (m.rq0_ready) begin seen = 1'b1; break; end
    end
    chk("rstmid_ready", 32'(seen), 32'd1);
    chk("rstmid_load_req_before", 32'(m.mem_load_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_load_req_after", 32'(m.mem_load_req), 32'd0);
    chk("rstmid_busy", 32'(m.busy), 32'd0);
    chk("rstmid_rs0_rdata", m.rs0_rdata, 32'd0);
    drive(0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (m.rs0_valid || m.rs1_valid || m.busy) bad = 1'b1;
    end
    chk("rstmid_no_rs_valid", 32'(bad), 32'd0);

    xact(0, 1'b0, 16'h0028, '0, 1'b0, "ld0_post_rst", lat, rd);
    chk("ld0_post_rst_latency", 32'(lat), 32'd3);
    chk("ld0_post_rst_rdata", rd, 32'h0000_0028);

    xact(0, 1'b0, 16'h0030, '0, 1'b1, "ld0_spur", lat, rd);
    chk("ld0_spur_latency", 32'(lat), 32'd3);
    chk("ld0_spur_rdata", rd, 32'h0000_0030);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, address width; DATA_W, default 32, cache-block width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-003 Requester ports (n = 0,1) SHALL be:
- rq<n>_valid  in  1  request pending.
- rq<n>_we  in  1  1 = block store, 0 = block load.
- rq<n>_addr  in  ADDR_W  block address.
- rq<n>_wdata  in  DATA_W  store block.
- rq<n>_ready  out  1  request accepted, one-cycle pulse.
- rs<n>_valid  out  1  transaction done, one-cycle pulse.
- rs<n>_rdata  out  DATA_W  load block.
REQ-004 Memory ports SHALL be:
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  store data.
- mem_wren  out  1  store request.
- mem_load_req  out  1  load request.
- mem_rdata  in  DATA_W  memory read data.
- mem_load_completed  in  1  load data valid.
- mem_store_completed  in  1  store written.
REQ-005 Status port SHALL be: busy  out  1  FSM not in IDLE.

Function
REQ-006 FSM states SHALL be IDLE, LOAD, STORE, STORE_REL and RESP, with a 3-bit registered state.
REQ-007 In IDLE with any rq<n>_valid, the arbiter SHALL select a winner, latch its addr, wdata, we and id, pulse rq<winner>_ready for that cycle, and move to LOAD if we=0 or STORE if we=1.
REQ-008 A loser's valid SHALL be ignored, with its ready kept 0; the requester holds valid until it sees ready.
REQ-009 LOAD SHALL drive mem_load_req=1 and mem_addr=latched addr until the cycle mem_load_completed=1, then capture mem_rdata into rs<id>_rdata and go to RESP.
REQ-010 STORE SHALL drive mem_wren=1 with latched mem_addr and mem_wdata until mem_store_completed=1, then drop mem_wren and go to STORE_REL.
REQ-011 STORE_REL SHALL hold until mem_store_completed=0, then go to RESP; this guarantees the memory has released before the next store.
REQ-012 RESP SHALL pulse rs<id>_valid for exactly one cycle, then go to IDLE.
REQ-013 rs<n>_rdata SHALL hold its last captured value until the next load for that port; a store SHALL NOT update it.
REQ-014 Minimum latency from accept to rs_valid SHALL be: load 3 cycles, store 4 cycles, with a memory that responds one cycle after request.
REQ-015 mem_load_req and mem_wren SHALL never be high in the same cycle.
REQ-016 mem_addr and mem_wdata SHALL remain stable for the whole of LOAD, STORE and STORE_REL.
REQ-017 Only one transaction SHALL be outstanding at a time; a new request is considered only in IDLE.
REQ-018 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from rq inputs to mem outputs.
REQ-019 A mem_load_completed or mem_store_completed arriving in any state other than the one that expects it SHALL be ignored.

Reset
REQ-020 Assertion of rst_n=0 SHALL immediately force:
- state = IDLE.
- all ready, valid, wren and load_req outputs = 0.
- mem_addr, mem_wdata, rs<n>_rdata = 0.
- busy = 0.
- priority pointer = port 0.
REQ-021 Reset mid-transaction SHALL abandon the transaction with no rs_valid pulse; after reset release the arbiter SHALL restart from IDLE on the next rising edge.

Configuration
REQ-022 With macro MEM_ARB_ROUND_ROBIN_EN defined, a 1-bit priority pointer SHALL favour the port not granted last; on a simultaneous request the favoured port wins, and the pointer updates on each grant.
REQ-023 Without MEM_ARB_ROUND_ROBIN_EN, port 0 SHALL always win a simultaneous request (fixed priority), and no pointer register SHALL exist.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Port 0 load, addr 0x0004, memory returns 0x00000004 one cycle after load_req -> rq0_ready pulse; rs0_valid exactly 3 cycles after accept; rs0_rdata=0x00000004.
- Port 1 store, addr 0x0008, wdata 0xDEADBEEF -> mem_wren high with stable addr/data until store_completed; rs1_valid after store_completed falls; memory location 0x0008=0xDEADBEEF.
- Both ports valid in the same cycle, four back-to-back pairs -> with ROUND_ROBIN_EN, grants 0,1,0,1; without it, port 0 granted all four times while holding valid.
- rst_n pulsed low during LOAD -> mem_load_req=0 immediately; no rs_valid; next port 0 load to 0x0028 completes with rdata 0x00000028.
- Spurious mem_store_completed while in LOAD -> ignored; load completes normally with correct data.
- Every cycle, by assertion: mem_wren and mem_load_req are never both 1; rs_valid is never high for two consecutive cycles.
